// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller that turns a dual-port memory
// (registered write, combinational read) into a first-word-fall-through
// queue. The controller owns both pointers, the occupancy count and the
// sticky overflow/underflow error flags.
//
// Handshake semantics (both sides):
//   Producer: a word is accepted at the rising edge where wr_en=1 and
//   full=0. With full=1, the push is dropped and ovf is set.
//   Consumer: rd_data is the head word whenever empty=0. That word is
//   consumed at the rising edge where rd_en=1 and empty=0. With empty=1,
//   the pop is ignored and udf is set.
//   The flags seen in the current cycle decide acceptance. A pop and a
//   push can both be accepted in the same cycle.
module fifo_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int AF_TH = 2**AW - 2,
  parameter int AE_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  output logic          mem_wr,
  output logic [AW-1:0] mem_wa,
  output logic [AW-1:0] mem_ra,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  // Thresholds are resized once to the count width, so the compares are
  // exact-width. The legal ranges (1..D and 0..D-1) fit in AW+1 bits.
  localparam logic [AW:0] AF_LIM = (AW+1)'(AF_TH);
  localparam logic [AW:0] AE_LIM = (AW+1)'(AE_TH);

  // Each pointer carries one extra wrap bit. That bit tells full apart
  // from empty when the low address bits are equal.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        push;
  logic        pop;

  // Status decode. All of it comes from registered pointers, so every
  // flag reflects the state after the last edge.
  always_comb begin
    empty        = (wptr == rptr);
    full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    count        = wptr - rptr;
    almost_full  = (count >= AF_LIM);
    almost_empty = (count <= AE_LIM);
  end

  // Accept logic. A blocked side does not stall the other side, so a pop
  // still goes through while full, and a push still goes through while
  // empty.
  always_comb begin
    push = wr_en && !full;
    pop  = rd_en && !empty;
  end

  // Memory drive. The write strobe is masked during rst and clr, so a
  // flush or reset never leaves a stray word behind. While full,
  // mem_wa == mem_ra. Because the push is rejected in that case, the
  // combinational read still returns the old head word.
  always_comb begin
    mem_wr  = push && !rst && !clr;
    mem_wa  = wptr[AW-1:0];
    mem_din = wr_data;
    mem_ra  = rptr[AW-1:0];
    rd_data = mem_dout;
  end

  // Pointer and sticky-error state. Priority is rst, then clr, then
  // push/pop. clr keeps the error history, but it also suppresses any new
  // error flagging in its own cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (wr_en && full)
        ovf <= 1'b1;
      if (rd_en && empty)
        udf <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO controller that sequences a dual-port memory (`mem_dp`: registered write, combinational read) into a first-word-fall-through queue. It owns the read/write pointers, occupancy count, full/empty and threshold flags, and sticky overflow/underflow errors. It sits between the producer/consumer interfaces and the memory instance in the FIFO top level.

## Interface
- `DW`, 16, data width; must equal the memory `DW`.
- `AW`, 4, address width; depth `D = 2**AW`.
- `AF_TH`, `2**AW-2`, almost-full threshold: `almost_full` when count >= `AF_TH`; legal range 1..D.
- `AE_TH`, 2, almost-empty threshold: `almost_empty` when count <= `AE_TH`; legal range 0..D-1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous flush: empties the FIFO and keeps error flags.
- `wr_en`  in  1  push request.
- `wr_data`  in  DW  push data.
- `rd_en`  in  1  pop request.
- `rd_data`  out  DW  head-of-queue data; valid when `empty`=0.
- `full`  out  1  count == D.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count >= AF_TH.
- `almost_empty`  out  1  count <= AE_TH.
- `count`  out  AW+1  current occupancy, 0..D.
- `ovf`  out  1  sticky: a push was attempted while full.
- `udf`  out  1  sticky: a pop was attempted while empty.
- `mem_wr`  out  1  memory write enable.
- `mem_wa`  out  AW  memory write address.
- `mem_ra`  out  AW  memory read address.
- `mem_din`  out  DW  memory write data.
- `mem_dout`  in  DW  memory read data (combinational from `mem_ra`).

## Operation
- State: `wptr`, `rptr` (AW+1 bits each, with the MSB as the wrap bit), `ovf`, `udf`. `count = wptr - rptr`, computed modulo 2^(AW+1).
- `empty = (wptr == rptr)`. `full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0])`.
- Push accepted: `push = wr_en && !full`. Pop accepted: `pop = rd_en && !empty`. Both use the flags from the current cycle.
- A push while full is dropped; `wptr` and the memory are unchanged, and `ovf` is set.
- A pop while empty is ignored; `rptr` is unchanged and `udf` is set.
- Memory drive:
  - `mem_wr = push`.
  - `mem_wa = wptr[AW-1:0]`.
  - `mem_din = wr_data`.
  - `mem_ra = rptr[AW-1:0]`.
  - `rd_data = mem_dout`.
- On an accepted push, `wptr` increments by 1. On an accepted pop, `rptr` increments by 1. Both wrap naturally at 2^(AW+1).
- Simultaneous push and pop when neither is blocked: both pointers advance and the count is unchanged.
- Push and pop while full: the pop is accepted, the push is rejected, and `ovf` is set. Count becomes D-1.
- Push and pop while empty: the push is accepted, the pop is rejected, and `udf` is set. Count becomes 1.
- Priority order: `rst` > `clr` > push/pop.
  - `clr`: `wptr = rptr = 0` and `mem_wr` is forced to 0. `ovf` and `udf` hold, and `wr_en`/`rd_en` that cycle do not update the error flags.
  - `rst`: pointers go to 0, `ovf = udf = 0`, and `mem_wr` is forced to 0.
- Memory contents are not cleared by `rst` or `clr`.

## Timing
- Reset values of all outputs:
  - `empty=1`, `full=0`, `almost_empty=1` (since AE_TH >= 0).
  - `almost_full=0`, `count=0`, `ovf=0`, `udf=0`.
  - `mem_wr=0`, `mem_wa=0`, `mem_ra=0`.
  - `rd_data` is undefined.
- All flags and `count` are decoded from registered pointers. They update in the cycle after the edge that accepted the push or pop.
- Write-to-read latency is 1 cycle. A word pushed at edge N is visible on `rd_data` with `empty=0` after edge N, including when the FIFO was empty.
- The pop handshake is FWFT: `rd_data` holds the head word while `empty=0`, and the pop is consumed at the edge where `rd_en=1`.
- Pop while full, with its accompanying write: `mem_wa == mem_ra`. The combinational read returns the old word before the edge; the push itself is rejected.
- Pointer wrap: after D pushes and D pops starting from reset, `wptr = rptr = D` with MSB set, and `empty=1`.
- `rst` asserted mid-traffic takes effect at that edge regardless of `wr_en`/`rd_en`.

## Test plan
- Reset, then push 0x0001..0x0010 (16 words, AW=4) → `full=1` and `count=16` after the 16th edge. Then push 0xDEAD → `ovf=1`, count stays 16, and the memory is not written.
- Pop 16 times from the full FIFO → `rd_data` sequence is 0x0001..0x0010, `empty=1` after the last pop. One more `rd_en` → `udf=1`, pointers unchanged.
- Empty FIFO with `wr_en=1`, `rd_en=1`, data 0x00AA → `count=1`, `udf=1`, `rd_data=0x00AA` next cycle.
- Full FIFO with `wr_en=1`, `rd_en=1` → popped word equals the oldest entry, `count=15`, `ovf=1`.
- Streaming: continuous push+pop for 40 cycles with count held at 3 → data order preserved across pointer wrap, `count` constant at 3, `almost_empty=0` with AE_TH=2.
- Fill to 10, assert `clr` together with `wr_en` → next cycle `count=0`, `empty=1`, prior `ovf`/`udf` preserved. Assert `rst` mid-stream → every output returns to its reset value in the following cycle.
